inst_mem: RTL and testbench

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem.sv | 53 +++++
 tb/tb_inst_mem.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem
// Description : 32-word instruction memory. Combinational read indexed by the
//               low ADDR_BITS of the word-index program counter, synchronous
//               program-load write port, synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PC,
  output logic [DATA_WIDTH-1:0] Inst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int c_DEPTH = 2 ** ADDR_BITS;

  // Storage kept as a plain unpacked array so a bench can preload it by
  // hierarchical assignment without clocking.
  logic [DATA_WIDTH-1:0] regfile [c_DEPTH];

  // PC is a word index; only the low ADDR_BITS select a word, so anything
  // above wraps and is intentionally discarded.
  logic [ADDR_BITS-1:0]  w_rd_idx;
  logic [31-ADDR_BITS:0] w_pc_hi_unused;

  assign w_rd_idx       = PC[ADDR_BITS-1:0];
  assign w_pc_hi_unused = PC[31:ADDR_BITS];

  // Zero-latency read: follows PC and the addressed word with no clock.
  // A same-index write therefore shows the old word until the edge and the
  // new word right after it.
  assign Inst = regfile[w_rd_idx];

  // Synchronous clear (wins over a write in the same cycle) or single write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        regfile[i] <= '0;
      end
    end else if (we) begin
      regfile[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem
// Description : Self-checking bench for inst_mem with a word-array reference
//               model and randomized program-load traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Inst;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_cmp;
  int n_err;

  logic [31:0] ref_mem [32];

  inst_mem #(.DATA_WIDTH(32), .ADDR_BITS(5)) uut (
    .clk     (clk),
    .reset   (reset),
    .PC      (PC),
    .Inst    (Inst),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: PC is a word index taken modulo the 32-word depth.
  function automatic logic [31:0] model_read(input logic [31:0] pc);
    return ref_mem[pc % 32];
  endfunction

  // Reference write behaviour of one rising edge.
  function automatic void model_edge(input logic rst, input logic wen,
                                     input logic [4:0] a, input logic [31:0] d);
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    end else if (wen) begin
      ref_mem[a] = d;
    end
  endfunction

  // Drive one cycle's inputs after the falling edge, then apply the edge.
  task automatic cycle(input logic rst, input logic wen,
                       input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reset = rst; we = wen; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_edge(rst, wen, a, d);
    #1;
  endtask

  task automatic load_identity();
    for (int i = 0; i < 32; i++) begin
      uut.regfile[i] = 32'(i);
      ref_mem[i]     = 32'(i);
    end
  endtask

  task automatic test_comb_sweep();
    load_identity();
    for (int p = 0; p < 32; p++) begin
      PC = 32'(p);
      #1;
      n_cmp++;
      if (Inst !== model_read(PC)) begin
        n_err++;
        $display("FAIL sweep pc=%0d got=%h exp=%h", p, Inst, model_read(PC));
      end
      #4;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [4];
    logic [31:0] exps [4];
    logic [31:0] rp;
    pcs[0] = 32'd32; pcs[1] = 32'd33; pcs[2] = 32'd63; pcs[3] = 32'hFFFF_FFFF;
    exps[0] = 32'd0; exps[1] = 32'd1; exps[2] = 32'd31; exps[3] = 32'd31;
    for (int k = 0; k < 4; k++) begin
      PC = pcs[k];
      #1;
      n_cmp++;
      if (Inst !== exps[k]) begin
        n_err++;
        $display("FAIL wrap pc=%h got=%h exp=%h", pcs[k], Inst, exps[k]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      rp = $urandom;
      PC = rp;
      #1;
      n_cmp++;
      if (Inst !== model_read(rp)) begin
        n_err++;
        $display("FAIL wrap_rand pc=%h got=%h exp=%h", rp, Inst, model_read(rp));
      end
    end
  endtask

  task automatic test_reset();
    // Reset with a competing write; nothing may change before the edge.
    @(negedge clk);
    PC = 32'd5;
    reset = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (Inst !== 32'd5) begin
      n_err++;
      $display("FAIL reset_async got=%h exp=%h", Inst, 32'd5);
    end
    @(posedge clk);
    model_edge(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    #1;
    @(negedge clk);
    reset = 1'b0; we = 1'b0;
    for (int p = 0; p < 32; p++) begin
      PC = 32'(p);
      #1;
      n_cmp++;
      if (Inst !== 32'h0) begin
        n_err++;
        $display("FAIL reset_clear pc=%0d got=%h exp=0", p, Inst);
      end
    end
    n_cmp++;
    if (uut.regfile[3] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_priority got=%h exp=0", uut.regfile[3]);
    end
  endtask

  task automatic test_write_first();
    logic [31:0] old7;
    logic [31:0] old6;
    logic [31:0] old8;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i]     = $urandom;
      uut.regfile[i] = ref_mem[i];
    end
    old7 = ref_mem[7]; old6 = ref_mem[6]; old8 = ref_mem[8];
    @(negedge clk);
    PC = 32'd7; reset = 1'b0; we = 1'b1; wr_addr = 5'd7; wr_data = 32'h2008_0005;
    #1;
    n_cmp++;
    if (Inst !== old7) begin
      n_err++;
      $display("FAIL wf_before got=%h exp=%h", Inst, old7);
    end
    @(posedge clk);
    model_edge(1'b0, 1'b1, 5'd7, 32'h2008_0005);
    #1;
    n_cmp++;
    if (Inst !== 32'h2008_0005) begin
      n_err++;
      $display("FAIL wf_after got=%h exp=%h", Inst, 32'h2008_0005);
    end
    n_cmp++;
    if (uut.regfile[6] !== old6 || uut.regfile[8] !== old8) begin
      n_err++;
      $display("FAIL wf_neighbours got=%h/%h exp=%h/%h",
               uut.regfile[6], uut.regfile[8], old6, old8);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_hold();
    cycle(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5);
    PC = 32'd31;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 5'($urandom), $urandom);
      n_cmp++;
      if (Inst !== 32'hA5A5_A5A5) begin
        n_err++;
        $display("FAIL hold cyc=%0d got=%h exp=a5a5a5a5", c, Inst);
      end
    end
  endtask

  task automatic test_mid_cycle();
    load_identity();
    @(posedge clk);
    #1;
    PC = 32'd4;
    #1;
    n_cmp++;
    if (Inst !== 32'd4) begin
      n_err++;
      $display("FAIL midcyc_a got=%h exp=4", Inst);
    end
    @(negedge clk);
    PC = 32'd9;
    #1;
    n_cmp++;
    if (Inst !== 32'd9) begin
      n_err++;
      $display("FAIL midcyc_b got=%h exp=9", Inst);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rp;
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 5'(i), $urandom);
    cycle(1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rp = 32'(i) + (32'($urandom_range(0, 7)) << 5);
      PC = rp;
      #1;
      n_cmp++;
      if (Inst !== model_read(rp)) begin
        n_err++;
        $display("FAIL b2b idx=%0d got=%h exp=%h", i, Inst, model_read(rp));
      end
    end
  endtask

  task automatic test_random();
    logic        r_rst;
    logic        r_we;
    logic [4:0]  r_a;
    logic [31:0] r_d;
    logic [31:0] rp;
    for (int c = 0; c < 200; c++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_a   = 5'($urandom);
      r_d   = $urandom;
      cycle(r_rst, r_we, r_a, r_d);
      rp = (c % 4 == 0) ? {27'($urandom), r_a} : $urandom;
      PC = rp;
      #1;
      n_cmp++;
      if (Inst !== model_read(rp)) begin
        n_err++;
        $display("FAIL random cyc=%0d pc=%h got=%h exp=%h", c, rp, Inst, model_read(rp));
      end
    end
  endtask

  task automatic test_midseq_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 5'(i), $urandom | 32'h1);
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    cycle(1'b0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      PC = 32'(i);
      #1;
      n_cmp++;
      if (Inst !== model_read(PC)) begin
        n_err++;
        $display("FAIL midseq_reset idx=%0d got=%h exp=%h", i, Inst, model_read(PC));
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; PC = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 'x;
    test_comb_sweep();
    test_wrap();
    test_reset();
    test_write_first();
    test_hold();
    test_mid_cycle();
    test_back_to_back();
    test_random();
    test_midseq_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
